// File: rtl/fpu_alloc_scheduler.sv
// fpu_alloc_scheduler: shares NB_APUS FPU units among NB_CORES cores.
// One operation is offered to a unit at a time; each unit keeps an in-order
// FIFO of the core IDs it has accepted so results can be routed back.
module fpu_alloc_scheduler #(
    parameter int NB_CORES        = 4,
    parameter int NB_APUS         = 2,
    parameter int MAX_OUTSTANDING = 2,
    localparam int CID_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1,
    localparam int AID_W = (NB_APUS > 1) ? $clog2(NB_APUS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NB_CORES-1:0] core_req_i,
    output logic [NB_CORES-1:0] core_gnt_o,
    output logic [NB_CORES-1:0] core_rvalid_o,
    output logic [NB_APUS-1:0]  apu_req_o,
    input  logic [NB_APUS-1:0]  apu_gnt_i,
    output logic [CID_W-1:0]    apu_id_o,
    output logic [AID_W-1:0]    apu_sel_o,
    input  logic [NB_APUS-1:0]  apu_rvalid_i,
    output logic [NB_APUS-1:0]  apu_busy_o,
    output logic                idle_o,
    output logic                err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CID_W-1:0] CID_LAST = CID_W'(NB_CORES - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CID_W-1:0]    r_core;
    logic [AID_W-1:0]    r_unit;
    logic [CID_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]    r_count  [NB_APUS];
    logic [PTR_W-1:0]    r_rd_ptr [NB_APUS];
    logic [PTR_W-1:0]    r_wr_ptr [NB_APUS];
    logic [CID_W-1:0]    r_fifo   [NB_APUS][MAX_OUTSTANDING];
    logic [NB_CORES-1:0] r_pending;
    logic                r_err;

    logic [NB_CORES-1:0] w_elig;
    logic                w_any_core;
    logic [CID_W-1:0]    w_pick_core;
    int                  w_best;
    int                  w_dist;
    logic [NB_APUS-1:0]  w_free;
    logic                w_any_unit;
    logic [AID_W-1:0]    w_pick_unit;
    logic                w_start;
    logic [NB_APUS-1:0]  w_sel_oh;
    logic [NB_APUS-1:0]  w_nonempty;
    logic                w_gnt_hit;
    logic [NB_APUS-1:0]  w_push;
    logic [NB_APUS-1:0]  w_pop;
    logic [NB_CORES-1:0] w_grant;
    logic [NB_CORES-1:0] w_rvalid;
    logic                w_err_evt;
    logic                w_all_empty;
    logic                w_issue;

    // Arbitration: round-robin core from rr_ptr, lowest-index unit with credit.
    always_comb begin
        w_elig      = core_req_i & ~r_pending;
        w_any_core  = |w_elig;
        w_pick_core = '0;
        w_best      = NB_CORES;
        w_dist      = 0;
        for (int i = 0; i < NB_CORES; i++) begin
            if (w_elig[i]) begin
                w_dist = (i >= int'(r_rr_ptr)) ? (i - int'(r_rr_ptr))
                                               : (i + NB_CORES - int'(r_rr_ptr));
                if (w_dist < w_best) begin
                    w_best      = w_dist;
                    w_pick_core = CID_W'(i);
                end
            end
        end
        w_pick_unit = '0;
        for (int j = 0; j < NB_APUS; j++) begin
            w_free[j] = (r_count[j] != CNT_MAX);
        end
        for (int j = NB_APUS - 1; j >= 0; j--) begin
            if (w_free[j]) begin
                w_pick_unit = AID_W'(j);
            end
        end
        w_any_unit = |w_free;
        w_start    = (r_state == S_IDLE) && w_any_core && w_any_unit;
    end

    // Grant/result routing and protocol error detection.
    always_comb begin
        w_grant     = '0;
        w_rvalid    = '0;
        w_all_empty = 1'b1;
        for (int j = 0; j < NB_APUS; j++) begin
            w_sel_oh[j]   = (r_unit == AID_W'(j));
            w_nonempty[j] = (r_count[j] != '0);
            w_pop[j]      = apu_rvalid_i[j] && w_nonempty[j];
            if (w_nonempty[j]) begin
                w_all_empty = 1'b0;
            end
        end
        w_gnt_hit = (r_state == S_ISSUE) && |(apu_gnt_i & w_sel_oh);
        for (int j = 0; j < NB_APUS; j++) begin
            w_push[j] = w_gnt_hit && w_sel_oh[j];
        end
        for (int c = 0; c < NB_CORES; c++) begin
            w_grant[c] = w_gnt_hit && (r_core == CID_W'(c));
        end
        for (int j = 0; j < NB_APUS; j++) begin
            for (int c = 0; c < NB_CORES; c++) begin
                if (w_pop[j] && (r_fifo[j][r_rd_ptr[j]] == CID_W'(c))) begin
                    w_rvalid[c] = 1'b1;
                end
            end
        end
        w_err_evt = ((r_state == S_ISSUE) ? |(apu_gnt_i & ~w_sel_oh) : |apu_gnt_i)
                  | |(apu_rvalid_i & ~w_nonempty);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: IDLE launches an offer, ISSUE waits for the unit grant.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start)   w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_gnt_hit) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latched offer (core/unit) and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_core   <= '0;
            r_unit   <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_start) begin
                r_core <= w_pick_core;
                r_unit <= w_pick_unit;
            end
            if (w_gnt_hit) begin
                r_rr_ptr <= (r_core == CID_LAST) ? '0 : r_core + CID_W'(1);
            end
        end
    end

    // Per-unit FIFO control: counts and wrapping pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NB_APUS; j++) begin
                r_count[j]  <= '0;
                r_rd_ptr[j] <= '0;
                r_wr_ptr[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NB_APUS; j++) begin
                if (w_push[j]) begin
                    r_wr_ptr[j] <= (r_wr_ptr[j] == PTR_LAST) ? '0 : r_wr_ptr[j] + PTR_W'(1);
                end
                if (w_pop[j]) begin
                    r_rd_ptr[j] <= (r_rd_ptr[j] == PTR_LAST) ? '0 : r_rd_ptr[j] + PTR_W'(1);
                end
                case ({w_push[j], w_pop[j]})
                    2'b10:   r_count[j] <= r_count[j] + CNT_W'(1);
                    2'b01:   r_count[j] <= r_count[j] - CNT_W'(1);
                    default: r_count[j] <= r_count[j];
                endcase
            end
        end
    end

    // FIFO storage: contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NB_APUS; j++) begin
            if (w_push[j]) begin
                r_fifo[j][r_wr_ptr[j]] <= r_core;
            end
        end
    end

    // Pending bits (a new grant cannot target a pending core) and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_rvalid) | w_grant;
            r_err     <= r_err | w_err_evt;
        end
    end

    // Outputs are forced quiet while reset is asserted.
    assign w_issue       = (r_state == S_ISSUE) && !rst;
    assign apu_req_o     = w_issue ? w_sel_oh : '0;
    assign apu_id_o      = w_issue ? r_core : '0;
    assign apu_sel_o     = w_issue ? r_unit : '0;
    assign core_gnt_o    = rst ? '0 : w_grant;
    assign core_rvalid_o = rst ? '0 : w_rvalid;
    assign idle_o        = rst | ((r_state == S_IDLE) && w_all_empty);
    assign err_o         = r_err & ~rst;

    generate
        for (genvar g = 0; g < NB_APUS; g++) begin : g_busy
            assign apu_busy_o[g] = (r_count[g] == CNT_MAX) && !rst;
        end
    endgenerate

endmodule
